// File: rtl/count_share_pkg.sv
// Shared types, widths and the reference ones-count for the count-sharing arbiter.
package count_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int VEC_W = 4;
    localparam int CNT_W = 3;

    function automatic logic [CNT_W-1:0] popcount4(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < VEC_W; i++) begin
            acc = acc + {2'b00, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/count_share_arbiter_counting_signals.sv
// Shared four-input ones-counter: a two-level adder tree over the signal vector.
module counting_signals
    import count_share_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [CNT_W-1:0] count
);

    logic [1:0] sum_ab;
    logic [1:0] sum_cd;

    assign sum_ab = {1'b0, vec[0]} + {1'b0, vec[1]};
    assign sum_cd = {1'b0, vec[2]} + {1'b0, vec[3]};
    assign count  = {1'b0, sum_ab} + {1'b0, sum_cd};

endmodule

// File: rtl/count_share_arbiter.sv
// Round-robin arbiter sharing one ones-counter among N_REQ requesters,
// with a single registered response slot that refills without a bubble.
module count_share_arbiter
    import count_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [VEC_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [CNT_W-1:0]       rsp_count
);

    slot_state_t      state;
    slot_state_t      state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  gnt_idx;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [VEC_W-1:0] sel_vec_p0;
    logic [CNT_W-1:0] count_p0;
    logic [CNT_W-1:0] count_p1;
    logic [ID_W-1:0]  id_p1;

    // Rotating-priority search: first valid requester at or above ptr, with wrap.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_nxt  = state;
        can_accept = (state == EMPTY) || rsp_ready;
        accept     = rst_n && can_accept && found;
        req_ready  = '0;
        if (accept) begin
            req_ready = N_REQ'(1) << gnt_idx;
        end
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        sel_vec_p0 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_vec_p0 = req_data[i*VEC_W +: VEC_W];
            end
        end
    end

    counting_signals u_counting_signals (
        .vec   (sel_vec_p0),
        .count (count_p0)
    );

    // p0 -> p1: the granted result lands in the response slot on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= '0;
            id_p1    <= '0;
            count_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr      <= ptr_nxt;
                id_p1    <= gnt_idx;
                count_p1 <= count_p0;
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_id    = id_p1;
    assign rsp_count = count_p1;

endmodule

// File: tb/tb_count_share_arbiter.sv
// Directed bench for count_share_arbiter with N_REQ=4.
module tb_count_share_arbiter;
    import count_share_pkg::*;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] req_valid;
    logic [4*N_REQ-1:0] req_data;
    logic [N_REQ-1:0] req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [2:0]       rsp_count;

    int n_cmp;
    int n_fail;

    count_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_data  = 16'hFFFF;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready cyc%0d got=%b exp=0000", c, req_ready); end
            step();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid cyc%0d got=%b exp=0", c, rsp_valid); end
            n_cmp++; if (rsp_count !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_count cyc%0d got=%0d exp=0", c, rsp_count); end
            n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id cyc%0d got=%0d exp=0", c, rsp_id); end
        end
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_req_ready cyc%0d got=%b exp=0000", c, req_ready); end
            step();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid cyc%0d got=%b exp=0", c, rsp_valid); end
        end
    endtask

    task automatic test_single();
        req_data  = 16'h0B00;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id got=%0d exp=2", rsp_id); end
        n_cmp++; if (rsp_count !== 3'd3) begin n_fail++; $display("FAIL single_rsp_count got=%0d exp=3", rsp_count); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id [5];
        logic [2:0] exp_cnt [5];
        logic [3:0] exp_rdy;
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_cnt = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0};
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_data  = {4'b1111, 4'b0111, 4'b0001, 4'b0000};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_rdy = 4'b0001 << exp_id[i];
            n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_req_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=1", i, rsp_valid); end
            n_cmp++; if (rsp_id !== exp_id[i]) begin n_fail++; $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", i, rsp_id, exp_id[i]); end
            n_cmp++; if (rsp_count !== exp_cnt[i]) begin n_fail++; $display("FAIL rr_rsp_count[%0d] got=%0d exp=%0d", i, rsp_count, exp_cnt[i]); end
        end
        req_valid = 4'b0000;
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        // Pointer sits at 1 after the previous scenario's final grant of requester 0.
        req_data  = 16'h0050;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_fill_ready got=%b exp=0010", req_ready); end
        step();
        rsp_ready = 1'b0;
        req_data  = 16'hE000;
        req_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready[%0d] got=%b exp=0000", c, req_ready); end
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", c, rsp_valid); end
            n_cmp++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_rsp_id[%0d] got=%0d exp=1", c, rsp_id); end
            n_cmp++; if (rsp_count !== 3'd2) begin n_fail++; $display("FAIL bp_rsp_count[%0d] got=%0d exp=2", c, rsp_count); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_after_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL bp_after_id got=%0d exp=3", rsp_id); end
        n_cmp++; if (rsp_count !== 3'd3) begin n_fail++; $display("FAIL bp_after_count got=%0d exp=3", rsp_count); end
        step();
    endtask

    task automatic test_reset_mid();
        req_data  = 16'h0300;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got=%b exp=1", rsp_valid); end
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_data  = 16'h001C;
        req_valid = 4'b0011;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=0000", req_ready); end
        step();
        rst_n = 1'b1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0010;
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_rsp_id0 got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_count !== 3'd2) begin n_fail++; $display("FAIL mid_rsp_count0 got=%0d exp=2", rsp_count); end
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_second_grant got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL mid_rsp_id1 got=%0d exp=1", rsp_id); end
        n_cmp++; if (rsp_count !== 3'd1) begin n_fail++; $display("FAIL mid_rsp_count1 got=%0d exp=1", rsp_count); end
        step();
    endtask

    task automatic test_exhaustive();
        logic [3:0] v;
        logic [2:0] exp_cnt;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            v        = 4'(i);
            exp_cnt  = popcount4(v);
            req_data = {12'h000, v};
            #1;
            n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ex_req_ready[%0d] got=%b exp=0001", i, req_ready); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL ex_rsp_tag[%0d] got=%b/%0d exp=1/0", i, rsp_valid, rsp_id); end
            n_cmp++; if (rsp_count !== exp_cnt) begin n_fail++; $display("FAIL ex_rsp_count[%0d] got=%0d exp=%0d", i, rsp_count, exp_cnt); end
            n_cmp++; if ((rsp_count == 3'd4) !== (i == 15)) begin n_fail++; $display("FAIL ex_max_only_ffff[%0d] got=%0d exp_max=%0d", i, rsp_count, (i == 15)); end
        end
        req_valid = 4'b0000;
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ex_drain got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/count_share_arbiter.md
# count_share_arbiter

Shares one four-input signal-counting datapath (`counting_signals`, 4 bits in, 3-bit ones-count out) among `N_REQ` requesters. Arbitration is round-robin; both sides use valid/ready handshakes. The block has one registered response slot, so it returns a tagged count one cycle after acceptance and sustains one count per cycle while the consumer keeps `rsp_ready` high. It sits between the signal-sampling front ends and the shared count consumer.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  N_REQ: bit i set means requester i presents a vector.
- `req_data`  in  4*N_REQ: nibble i is requester i's vector, bit0=a, bit1=b, bit2=c, bit3=d.
- `req_ready`  out  N_REQ: one-hot or zero; bit i set means requester i is accepted this cycle.
- `rsp_valid`  out  1: response slot holds a result.
- `rsp_ready`  in  1: consumer takes the response this cycle.
- `rsp_id`  out  ID_W: index of the requester that owns the response.
- `rsp_count`  out  3: number of ones in that requester's vector, range 0..4.

## Operation
- Slot FSM:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `can_accept` = EMPTY, or FULL with `rsp_ready`=1.
- Transitions:
  - EMPTY, no request: stay EMPTY.
  - EMPTY, grant: go FULL.
  - FULL, `rsp_ready`=0: stay FULL and hold all outputs stable.
  - FULL, `rsp_ready`=1, grant: stay FULL and load the new result in the same cycle, with no bubble.
  - FULL, `rsp_ready`=1, no request: go EMPTY.
- Arbitration:
  - Only when `can_accept`=1.
  - Grant the first set `req_valid` bit, searching upward (with wrap) from `ptr`.
  - Exactly that `req_ready` bit goes high; the handshake completes combinationally in that cycle.
- Pointer:
  - On each accept, `ptr` becomes granted index + 1, modulo `N_REQ`.
  - `ptr` does not change on cycles with no accept.
- Load on accept: `rsp_count` = popcount of the granted nibble, computed by the shared datapath; `rsp_id` = granted index.
- `req_ready` may depend on `req_valid`. A requester must hold `req_valid` and `req_data` until it is accepted.
- Fairness: a requester holding `req_valid` high is granted within `N_REQ` accepts.
- Arithmetic: the count is 3 bits unsigned with no saturation needed, since the maximum is 4 (3'b100).
- `rsp_count` and `rsp_id` are don't-care while `rsp_valid`=0, but they keep their last loaded values.

## Timing
- Reset (`rst_n`=0 at an edge):
  - FSM goes EMPTY; `rsp_valid`=0, `rsp_id`=0, `rsp_count`=0.
  - `ptr`=0, so requester 0 has highest priority.
  - `req_ready` is all-zero while `rst_n`=0.
- Reset mid-operation: any held response is discarded with no output. A request presented in a reset cycle is not accepted.
- Latency: accept at edge n, response visible after edge n, so `rsp_valid`=1 in cycle n+1.
- Throughput: one response per cycle while `rsp_ready`=1 and at least one request is pending.
- Backpressure: FULL with `rsp_ready`=0 forces all `req_ready` low in the same cycle (combinational from `rsp_ready`).
- Simultaneous drain and accept: the old response is consumed and the new one is loaded at the same edge.
- Wrap-around: when `ptr`=`N_REQ`-1 and requester `N_REQ`-1 is granted, `ptr` becomes 0.
- No combinational path from `req_data` to any output.

## Structure
- Package `count_share_pkg` holds:
  - the slot-state enum (EMPTY, FULL);
  - `VEC_W`=4 and `CNT_W`=3;
  - a `popcount4` function usable as the golden model.
- Sub-module: one instance of `counting_signals`, fed by a `VEC_W`-wide mux selected by the grant index.
- The arbiter lives in this module: rotate-priority search, pointer register, grant encoder.

## Test plan
- Reset then idle, `rst_n` low for 2 cycles: `rsp_valid`=0, `rsp_count`=0, `rsp_id`=0, `req_ready`=0. After release with no requests, state remains EMPTY.
- Single requester 2, data 4'b1011, `rsp_ready`=1: `req_ready`=4'b0100 in the same cycle. Next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_count`=3'd3.
- All four requesters valid continuously, data 0000/0001/0111/1111, `rsp_ready`=1:
  - grant order 0,1,2,3,0;
  - counts 0,1,3,4,0;
  - one response per cycle with no gaps.
- Backpressure: FULL with id 1 and count 2, `rsp_ready`=0 for 3 cycles while requester 3 is valid:
  - outputs stay id 1 / count 2 and `req_ready`=0;
  - when `rsp_ready` rises, requester 3 is accepted that cycle and its result appears the next cycle.
- Reset mid-operation: FULL with `rsp_ready`=0 when `rst_n` goes low for 1 cycle: `rsp_valid`=0 next cycle and `ptr` is back to 0. With requesters 1 and 0 both valid afterwards, requester 0 is granted first.
- Exhaustive check: all 16 vectors on requester 0, each checked against `popcount4`; `rsp_count`=4 only for 4'b1111.
